seq_mul_datapath: RTL and testbench
===================================

# seq_mul_datapath

Datapath for the sequential shift-add multiplier. It holds the multiplicand, the multiplier shift register, the partial-product accumulator and the iteration counter, and it executes the add, shift and count strobes issued by the multiplier control FSM. It returns `multiplier` and `count_value` to the FSM for branching. When the FSM raises `ready`, it latches and publishes the final product.

## Interface
- `N`, 4: operand width in bits (unsigned).
- `CW`, 3: counter width. Requires N+1 ≤ 2^CW − 1.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `load`  in  1  operand capture strobe; pulsed alongside the FSM `start`.
- `a_in`  in  N  multiplicand.
- `b_in`  in  N  multiplier.
- `add_multiplicant`  in  1  add strobe from the FSM.
- `shift_multiplier_rigth`  in  1  shift strobe from the FSM.
- `count_start`  in  1  iteration-count strobe from the FSM.
- `ready`  in  1  done level from the FSM; held high while the FSM is in its final state.
- `multiplier`  out  N+1  multiplier shift register; bit 0 is the FSM branch bit.
- `count_value`  out  CW  iterations completed.
- `product`  out  2N  registered result.
- `product_valid`  out  1  one-cycle pulse when `product` updates.

## Operation
- Registers:
  - `mcand` (N+1): a_in, zero-extended.
  - `acc` (N+1): accumulator.
  - `mreg` (N+1): `multiplier` output.
  - `cnt` (CW): `count_value` output.
  - `prod` (2N), `pv`, `ready_d`.
- Reset (`rst`=1 at a clock edge) clears every register to 0:
  - `multiplier`=0, `count_value`=0, `product`=0, `product_valid`=0.
- Priority each cycle: rst > load > strobes.
- `load`:
  - `mcand`←{0,a_in}, `mreg`←{0,b_in}, `acc`←0, `cnt`←0.
  - Strobes in the same cycle are ignored.
  - `prod` is retained.
  - A `load` mid-operation aborts the operation and restarts cleanly.
- `add_multiplicant`=1: `acc`←`acc`+`mcand`, modulo 2^(N+1). The carry always fits in a legal sequence.
- `shift_multiplier_rigth`=1: the 2N+2-bit concatenation {`acc`,`mreg`} shifts right by 1 with 0 shifted in at the MSB.
  - `acc` bit 0 moves into `mreg` bit N.
  - `mreg` bit 0 is discarded.
- Add and shift in the same cycle (the FSM never issues this; behaviour is still defined): {`acc`+`mcand`, `mreg`}>>1 in one step.
- `count_start`=1: `cnt`←`cnt`+1, saturating at 2^CW−1 (no wrap). Independent of add/shift.
- Algorithm with the FSM:
  - N+1 add-or-skip decisions on `mreg[0]`, N shifts.
  - The top `mreg` bit is 0, so the final decision is always skip.
  - Final result = {`acc`[N-1:0], `mreg`[N:1]}.
- Product capture:
  - `ready_d` registers `ready`.
  - On a cycle with `ready`=1 and `ready_d`=0: `prod`←{`acc`[N-1:0], `mreg`[N:1]} and `pv`←1.
  - Otherwise `pv`←0.
  - `ready` held high for many cycles produces exactly one pulse.
  - `ready` rising in the same cycle as `load` or `rst`: the higher-priority action wins and no capture occurs (`ready_d` still updates).

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Strobe effects appear on outputs one cycle after the strobe cycle.
- `count_start` in cycle t produces the incremented `count_value` in cycle t+1. This matches the FSM's check one state later.
- `load` in cycle t makes `multiplier`={0,b_in} visible in cycle t+1. The FSM tests bit 0 in that cycle.
- `ready` rising in cycle t: `product` and `product_valid`=1 are visible in t+1, and `product_valid`=0 in t+2.
- Full N=4 run with the FSM:
  - 5 iterations of 5 FSM states, with the last iteration ending in the done state instead of shift.
  - `product_valid` occurs 1 cycle after `ready` rises.
- Throughput: one multiply per load/ready cycle. A new `load` may follow the `product_valid` cycle immediately.

## Test plan
- Reset, then `load` a_in=13, b_in=11, run with the FSM → `count_value` steps 1..5, `product`=143, single `product_valid` pulse one cycle after `ready` rises.
- Corner operands 15×15, 0×9, 9×0, 1×1 → `product`=225, 0, 0, 1; `acc` never overflows.
- `load` 6×7, then after 2 iterations `load` 5×3 → first result discarded, `count_value` returns to 0, final `product`=15.
- Directed strobes without the FSM: `mcand`=5, `mreg`=0b00011, assert add and shift in the same cycle → {`acc`,`mreg`}=(0b00101<<5 | 0b00011)>>1, i.e. `acc`=0b00010, `mreg`=0b10001. Hold `count_start` for 9 cycles → `count_value` saturates at 7.
- Hold `ready` high for 10 cycles → exactly one `product_valid` pulse; `product` stable afterward.
- Assert `rst` mid-multiply and in the same cycle as `ready` rising → all outputs 0 the next cycle, no `product_valid`; the next `load` 3×4 gives `product`=12.

Source files
------------

// File: rtl/seq_mul_datapath.sv
// rtl/seq_mul_datapath.sv - shift-add multiplier datapath: operand registers, accumulator, counter, product capture
module seq_mul_datapath #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    input  logic           add_multiplicant,
    input  logic           shift_multiplier_rigth,
    input  logic           count_start,
    input  logic           ready,
    output logic [N:0]     multiplier,
    output logic [CW-1:0]  count_value,
    output logic [2*N-1:0] product,
    output logic           product_valid
);

    logic [N:0]     mcand_q;
    logic [N:0]     acc_q, acc_d;
    logic [N:0]     mreg_q, mreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] prod_q;
    logic           pv_q;
    logic           ready_q;
    logic [N:0]     acc_src;
    logic           capture;

    // Add feeds the shift directly so a combined strobe is one {acc+mcand, mreg} >> 1 step.
    always_comb begin
        acc_src = add_multiplicant ? (acc_q + mcand_q) : acc_q;
        acc_d   = acc_src;
        mreg_d  = mreg_q;
        if (shift_multiplier_rigth) begin
            acc_d  = {1'b0, acc_src[N:1]};
            mreg_d = {acc_src[0], mreg_q[N:1]};
        end
        cnt_d = cnt_q;
        if (count_start && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        capture = ready && !ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mreg_q  <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            pv_q    <= 1'b0;
            ready_q <= 1'b0;
        end else if (load) begin
            mcand_q <= {1'b0, a_in};
            mreg_q  <= {1'b0, b_in};
            acc_q   <= '0;
            cnt_q   <= '0;
            pv_q    <= 1'b0;
            ready_q <= ready;
        end else begin
            acc_q   <= acc_d;
            mreg_q  <= mreg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready;
            if (capture) begin
                prod_q <= {acc_q[N-1:0], mreg_q[N:1]};
                pv_q   <= 1'b1;
            end else begin
                pv_q   <= 1'b0;
            end
        end
    end

    assign multiplier    = mreg_q;
    assign count_value   = cnt_q;
    assign product       = prod_q;
    assign product_valid = pv_q;

endmodule

// File: tb/tb_seq_mul_datapath.sv
// tb/tb_seq_mul_datapath.sv - scoreboard bench for seq_mul_datapath with a behavioural control FSM
module tb_seq_mul_datapath;
    localparam int N  = 4;
    localparam int CW = 3;

    logic           clk;
    logic           rst;
    logic           load;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic           add_multiplicant;
    logic           shift_multiplier_rigth;
    logic           count_start;
    logic           ready;
    logic [N:0]     multiplier;
    logic [CW-1:0]  count_value;
    logic [2*N-1:0] product;
    logic           product_valid;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_q[$];

    seq_mul_datapath #(.N(N), .CW(CW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .load                   (load),
        .a_in                   (a_in),
        .b_in                   (b_in),
        .add_multiplicant       (add_multiplicant),
        .shift_multiplier_rigth (shift_multiplier_rigth),
        .count_start            (count_start),
        .ready                  (ready),
        .multiplier             (multiplier),
        .count_value            (count_value),
        .product                (product),
        .product_valid          (product_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every product_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (product_valid) begin
            if (exp_q.size() == 0) check("pv_without_ready", product_valid, 0);
            else check("product", product, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_load(input int a, input int b);
        a_in = a[N-1:0];
        b_in = b[N-1:0];
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Behavioural control: decide add, count, then shift or finish.
    task automatic run_fsm(input int iters, input int hold, input int exp);
        for (int it = 0; it < iters; it++) begin
            add_multiplicant = multiplier[0];
            tick();
            add_multiplicant = 1'b0;
            count_start = 1'b1;
            tick();
            count_start = 1'b0;
            check("count_value", count_value, it + 1);
            if (it == N) begin
                exp_q.push_back(exp);
                ready = 1'b1;
                repeat (hold) tick();
                ready = 1'b0;
                tick();
                check("product_hold", product, exp);
            end else begin
                shift_multiplier_rigth = 1'b1;
                tick();
                shift_multiplier_rigth = 1'b0;
            end
        end
    endtask

    int ca[4] = '{15, 0, 9, 1};
    int cb[4] = '{15, 9, 0, 1};
    int cp[4] = '{225, 0, 0, 1};

    initial begin
        rst = 1'b1;
        load = 1'b0;
        a_in = '0;
        b_in = '0;
        add_multiplicant = 1'b0;
        shift_multiplier_rigth = 1'b0;
        count_start = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        check("rst_multiplier", multiplier, 0);
        check("rst_count", count_value, 0);
        check("rst_product", product, 0);
        check("rst_pv", product_valid, 0);
        rst = 1'b0;
        tick();

        do_load(13, 11);
        check("load_multiplier", multiplier, 11);
        run_fsm(N + 1, 3, 143);

        for (int i = 0; i < 4; i++) begin
            do_load(ca[i], cb[i]);
            run_fsm(N + 1, 3, cp[i]);
        end

        do_load(6, 7);
        run_fsm(2, 0, 0);
        do_load(5, 3);
        check("abort_count", count_value, 0);
        check("abort_multiplier", multiplier, 3);
        run_fsm(N + 1, 3, 15);

        do_load(5, 3);
        add_multiplicant = 1'b1;
        shift_multiplier_rigth = 1'b1;
        tick();
        add_multiplicant = 1'b0;
        shift_multiplier_rigth = 1'b0;
        check("add_shift_mreg", multiplier, 17);
        exp_q.push_back(40);
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        tick();
        count_start = 1'b1;
        repeat (9) tick();
        count_start = 1'b0;
        check("count_saturate", count_value, 7);

        do_load(2, 5);
        run_fsm(N + 1, 10, 10);

        do_load(7, 9);
        run_fsm(2, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_multiplier", multiplier, 0);
        check("midrst_count", count_value, 0);
        check("midrst_product", product, 0);
        check("midrst_pv", product_valid, 0);

        do_load(7, 9);
        rst = 1'b1;
        ready = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b0;
        check("rstready_pv", product_valid, 0);
        check("rstready_product", product, 0);
        check("rstready_multiplier", multiplier, 0);
        tick();
        check("rstready_pv_next", product_valid, 0);

        do_load(3, 4);
        run_fsm(N + 1, 3, 12);

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
